// File: rtl/dot8_row_sequencer.sv
// Issues a row of 8-wide operand beats to one dot pipeline, feeding each result back as the next running_sum.
// One beat per DOT_LAT+1 cycles; in_ready is low while a beat is in flight or a row sum waits on out_ready.
module dot8_row_sequencer #(
  parameter int DOT_LAT = 24,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_a,
  input  logic [255:0]     in_b,
  input  logic             in_last,
  output logic             dot_en,
  output logic [31:0]      dot_running_sum,
  output logic [255:0]     dot_a,
  output logic [255:0]     dot_b,
  input  logic [31:0]      dot_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_beats,
  output logic             busy
);

  localparam int WW = $clog2(DOT_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

  state_t           state;
  logic [WW-1:0]    wcnt;
  logic [31:0]      acc;
  logic [CNT_W-1:0] beats;
  logic             first;
  logic             last_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      wcnt            <= '0;
      acc             <= '0;
      beats           <= '0;
      first           <= 1'b1;
      last_r          <= 1'b0;
      in_ready        <= 1'b0;
      dot_en          <= 1'b0;
      dot_running_sum <= '0;
      dot_a           <= '0;
      dot_b           <= '0;
      out_valid       <= 1'b0;
      out_sum         <= '0;
      out_beats       <= '0;
      busy            <= 1'b0;
    end else begin
      dot_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            dot_a           <= in_a;
            dot_b           <= in_b;
            dot_running_sum <= first ? 32'd0 : acc;
            last_r          <= in_last;
            if (beats != {CNT_W{1'b1}}) beats <= beats + 1'b1;
            first           <= 1'b0;
            wcnt            <= '0;
            in_ready        <= 1'b0;
            busy            <= 1'b1;
            state           <= S_WAIT;
          end else begin
            in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          wcnt <= wcnt + 1'b1;
          // wcnt reaches DOT_LAT-1 exactly on the edge where the issued beat's result is valid
          if (wcnt == WW'(DOT_LAT - 1)) begin
            acc <= dot_result;
            if (last_r) begin
              out_valid <= 1'b1;
              out_sum   <= dot_result;
              out_beats <= beats;
              state     <= S_OUT;
            end else begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            first     <= 1'b1;
            beats     <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot8_row_sequencer.sv
// Bench for dot8_row_sequencer: directed table of rows, reset-in-flight sequence, and random rows against an integer-valued model.
module tb_dot8_row_sequencer;

  localparam int DOT_LAT = 24;
  localparam int LIMIT   = 2000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid, in_last, out_ready;
  logic [255:0] in_a, in_b;

  logic         in_ready, dot_en, out_valid, busy;
  logic [31:0]  dot_running_sum, dot_result, out_sum;
  logic [255:0] dot_a, dot_b;
  logic [15:0]  out_beats;

  logic         s_in_ready, s_dot_en, s_out_valid, s_busy;
  logic [31:0]  s_dot_running_sum, s_dot_result, s_out_sum;
  logic [255:0] s_dot_a, s_dot_b;
  logic [1:0]   s_out_beats;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot8_row_sequencer #(.DOT_LAT(DOT_LAT), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .dot_en(dot_en),
    .dot_running_sum(dot_running_sum), .dot_a(dot_a), .dot_b(dot_b),
    .dot_result(dot_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats), .busy(busy)
  );

  // Narrow-counter instance run in lockstep on the same stimulus
  dot8_row_sequencer #(.DOT_LAT(DOT_LAT), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .dot_en(s_dot_en),
    .dot_running_sum(s_dot_running_sum), .dot_a(s_dot_a), .dot_b(s_dot_b),
    .dot_result(s_dot_result), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_beats(s_out_beats), .busy(s_busy)
  );

  // Floats used here are always non-negative integers below 2^24, so conversion is exact.
  function automatic logic [31:0] i2f(input longint v);
    int p;
    logic [63:0] sh;
    if (v == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 24; i++) if (v[i]) p = i;
    sh = 64'(v) << (23 - p);
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  function automatic longint f2i(input logic [31:0] f);
    int e;
    logic [23:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {1'b1, f[22:0]};
    return longint'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] dot_fn(input logic [255:0] a, input logic [255:0] b,
                                         input logic [31:0] rs);
    longint s;
    s = f2i(rs);
    for (int i = 0; i < 8; i++) s += f2i(a[32*i +: 32]) * f2i(b[32*i +: 32]);
    return i2f(s);
  endfunction

  // Behavioural dot unit: result for operands held after edge T is visible before edge T+DOT_LAT
  logic [31:0] pipe   [DOT_LAT-1];
  logic [31:0] s_pipe [DOT_LAT-1];
  always @(posedge clk) begin
    pipe[0]   <= dot_fn(dot_a, dot_b, dot_running_sum);
    s_pipe[0] <= dot_fn(s_dot_a, s_dot_b, s_dot_running_sum);
    for (int i = 1; i < DOT_LAT - 1; i++) begin
      pipe[i]   <= pipe[i-1];
      s_pipe[i] <= s_pipe[i-1];
    end
  end
  assign dot_result   = pipe[DOT_LAT-2];
  assign s_dot_result = s_pipe[DOT_LAT-2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [255:0] beat_a [8];
  logic [255:0] beat_b [8];
  longint       beat_p [8];

  task automatic fill_fixed(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        beat_a[k][32*i +: 32] = 32'h3F800000;
        beat_b[k][32*i +: 32] = 32'h40000000;
      end
      beat_p[k] = 16;
    end
  endtask

  task automatic fill_rand(input int n);
    longint va, vb;
    for (int k = 0; k < n; k++) begin
      beat_p[k] = 0;
      for (int i = 0; i < 8; i++) begin
        va = longint'($urandom_range(0, 15));
        vb = longint'($urandom_range(0, 15));
        beat_a[k][32*i +: 32] = i2f(va);
        beat_b[k][32*i +: 32] = i2f(vb);
        beat_p[k] += va * vb;
      end
    end
  endtask

  task automatic cycle1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int k = 0;
    while (!in_ready && k < LIMIT) begin cycle1(); k++; end
    ok = in_ready;
    if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_row(input int n, input int stall, input int bp,
                         output logic [31:0] sum_o, output int beats_o, output int beats_s_o);
    longint acc_m = 0;
    int tprev = 0, tacc, k;
    bit ok;
    sum_o = 32'hx; beats_o = -1; beats_s_o = -1;
    for (int bt = 0; bt < n; bt++) begin
      if (bt > 0) repeat (stall) cycle1();
      in_a = beat_a[bt]; in_b = beat_b[bt]; in_last = (bt == n - 1); in_valid = 1'b1;
      wait_ready(ok);
      if (!ok) begin in_valid = 1'b0; return; end
      cycle1();
      tacc = cyc;
      in_valid = 1'b0;
      chk("dot_a", dot_a, beat_a[bt]);
      chk("dot_b", dot_b, beat_b[bt]);
      chk("running_sum", dot_running_sum, i2f(acc_m));
      chk("busy_after_accept", busy, 1);
      chk("in_ready_after_accept", in_ready, 0);
      if (bt > 0 && stall == 0) chk("beat_spacing", 64'(tacc - tprev), DOT_LAT + 1);
      tprev = tacc;
      acc_m += beat_p[bt];
    end
    k = 0;
    while (!out_valid && k < LIMIT) begin cycle1(); k++; end
    chk("out_latency", k, DOT_LAT);
    if (!out_valid) return;
    chk("out_sum", out_sum, i2f(acc_m));
    chk("sat_out_sum", s_out_sum, i2f(acc_m));
    sum_o = out_sum; beats_o = int'(out_beats); beats_s_o = int'(s_out_beats);
    in_valid = 1'b1;
    for (int i = 0; i < bp; i++) begin
      cycle1();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, sum_o);
      chk("bp_out_beats", out_beats, beats_o);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle1();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_rise", in_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  typedef struct {
    int          n;
    int          stall;
    int          bp;
    logic [31:0] exp_sum;
    int          exp_beats;
    int          exp_beats_sat;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] got_sum;
  int          got_beats, got_beats_s;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int nr;
    longint racc;
    vecs[0] = '{1, 0, 0,  32'h41800000, 1, 1};
    vecs[1] = '{4, 0, 0,  32'h42800000, 4, 3};
    vecs[2] = '{1, 0, 50, 32'h41800000, 1, 1};
    vecs[3] = '{2, 100, 0, 32'h42000000, 2, 2};
    vecs[4] = '{5, 0, 0,  32'h42A00000, 5, 3};

    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_dot_en", dot_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_beats", out_beats, 0);
    chk("rst_dot_rs", dot_running_sum, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("release_in_ready_low", in_ready, 0);
    cycle1();
    chk("release_in_ready", in_ready, 1);
    chk("release_dot_en", dot_en, 1);

    foreach (vecs[v]) begin
      fill_fixed(vecs[v].n);
      run_row(vecs[v].n, vecs[v].stall, vecs[v].bp, got_sum, got_beats, got_beats_s);
      chk("tbl_sum", got_sum, vecs[v].exp_sum);
      chk("tbl_beats", got_beats, vecs[v].exp_beats);
      chk("tbl_beats_sat", got_beats_s, vecs[v].exp_beats_sat);
    end

    // Reset while the first beat of a 3-beat row is in flight
    fill_fixed(3);
    in_a = beat_a[0]; in_b = beat_b[0]; in_last = 1'b0; in_valid = 1'b1;
    wait_ready(ok);
    cycle1();
    in_valid = 1'b0;
    repeat (10) cycle1();
    chk("mid_no_out_valid", out_valid, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_in_ready", in_ready, 0);
    chk("async_dot_en", dot_en, 0);
    chk("async_busy", busy, 0);
    chk("async_dot_a", dot_a, 0);
    chk("async_dot_b", dot_b, 0);
    chk("async_out_valid", out_valid, 0);
    repeat (3) cycle1();
    reset_n = 1'b1;
    chk("rerelease_in_ready_low", in_ready, 0);
    cycle1();
    chk("rerelease_in_ready", in_ready, 1);
    fill_fixed(1);
    run_row(1, 0, 0, got_sum, got_beats, got_beats_s);
    chk("post_reset_sum", got_sum, 32'h41800000);
    chk("post_reset_beats", got_beats, 1);

    for (int r = 0; r < 6; r++) begin
      nr = int'($urandom_range(1, 6));
      fill_rand(nr);
      racc = 0;
      for (int k = 0; k < nr; k++) racc += beat_p[k];
      run_row(nr, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              got_sum, got_beats, got_beats_s);
      chk("rand_sum", got_sum, i2f(racc));
      chk("rand_beats", got_beats, nr);
      chk("rand_beats_sat", got_beats_s, (nr > 3) ? 3 : nr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
